rx_bit_timer: RTL
=================

# rx_bit_timer

Bit-timing controller for the serial receive path. On a start request it waits half a bit period to reach mid-bit, then emits one sample strobe per bit period for a fixed number of bits, and signals frame completion. Two internal rollover counters do the work, one for the bit period and one for the bit count. The receive shift register and the frame FSM consume its strobes, and it sits between edge detection and data capture.

## Interface
- CLKS_PER_BIT, 8: clock cycles per serial bit (P); even, ≥4.
- BITS_PER_FRAME, 8: sample strobes per frame (N); ≥1.
- CNT_BITS, 4: period counter width; must hold P−1.
- IDX_BITS, 4: bit-count width; must hold N.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset; synchronous and active-high (clock `clk`, reset `rst`; polarity and synchronicity are fixed).
- start  in  1  begin a frame; honoured only in IDLE.
- abort  in  1  cancel the frame in progress; synchronous.
- busy  out  1  frame in progress (state ≠ IDLE).
- sample_strobe  out  1  one-cycle pulse at each mid-bit sample point.
- bit_count  out  IDX_BITS  number of strobes issued in the current frame.
- frame_done  out  1  one-cycle pulse in the cycle of the Nth strobe.

## Operation
- States:
  - IDLE: wait for start.
  - HALF: wait out half a bit to reach mid-bit.
  - RUN: count bit periods and emit strobes.
  - DONE: one-cycle completion state.
- H = P/2.
- IDLE behaviour:
  - Period counter and bit_count are held at 0.
  - start=1 and abort=0 → HALF, with the period counter at 0.
- HALF behaviour:
  - The period counter increments each cycle.
  - At count == H−1, the next state is RUN, the counter goes to 0, sample_strobe is set and bit_count becomes 1.
- RUN behaviour:
  - The period counter increments and wraps at P−1 back to 0.
  - On each wrap, sample_strobe is set and bit_count increments.
  - The wrap that produces strobe N sends the state to DONE.
  - If N=1, HALF goes directly to DONE.
- DONE behaviour:
  - Lasts exactly one cycle, with frame_done=1, then returns to IDLE.
  - bit_count holds N during DONE and clears to 0 on entering IDLE.
  - start during DONE is ignored.
- Priority, highest first: rst, then abort, then normal sequencing.
- abort in any non-IDLE state:
  - Next cycle: IDLE, counters at 0, no strobe, no frame_done.
  - abort together with start in IDLE: stay in IDLE.
- start is level-sampled. If start is held high, a new frame begins on the first IDLE cycle after DONE.
- Arithmetic is unsigned.
  - The period counter never exceeds P−1.
  - bit_count never exceeds N.
  - There is no overflow path.

## Timing
- All outputs are registered.
- Reset values: busy=0, sample_strobe=0, bit_count=0, frame_done=0, state=IDLE.
- With start sampled in cycle 0:
  - busy rises in cycle 1.
  - Strobes occur in cycles H+1+k·P, for k = 0…N−1.
  - The last strobe is in cycle L = H+1+(N−1)·P; frame_done=1 and busy=1 in L.
  - busy=0 in cycle L+1.
- rst asserted in any cycle → all outputs at their reset values in the next cycle; any frame in progress is discarded.
- abort in cycle c → busy=0 and no pulses in cycle c+1.
- sample_strobe and frame_done are never high for two consecutive cycles, except when P ≥ 4 is violated.

## Structure
- Shared package rx_pkg holds:
  - typedef enum logic [1:0] rx_timer_state_t {IDLE, HALF, RUN, DONE};
  - a helper constant for the half-period derivation.
- Sub-module sync_rollover_counter:
  - Parameterised width; synchronous active-high reset.
  - Inputs: clear, count_enable, rollover_val.
  - Outputs: count_out, rollover_flag.
  - Instantiated twice: once for the bit period and once for the bit count.
- The top level holds the FSM and the output registers.

## Test plan
- Reset, then one frame with P=8, N=8, start pulsed in cycle 0:
  - strobes in cycles 5, 13, 21, 29, 37, 45, 53, 61;
  - frame_done only in cycle 61;
  - busy high in cycles 1–61;
  - bit_count steps 1→8, then 0 in cycle 62.
- abort asserted in cycle 20: no strobe at 21; busy=0 in cycle 21; bit_count=0; a fresh start then reproduces the nominal timing.
- rst asserted in cycle 30 mid-frame: every output is 0 in cycle 31 and no frame_done appears.
- start and abort high together in IDLE: busy stays 0 and no strobes appear.
- start held high continuously: the second frame's busy rises in cycle 63 and its first strobe is in cycle 67.
- N=1, P=4: a single strobe and frame_done in cycle 3, and busy=0 in cycle 4.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared types and constants for the receive bit-timing path.
package rx_pkg;

    // Bit-timer FSM states.
    typedef enum logic [1:0] {
        IDLE,
        HALF,
        RUN,
        DONE
    } rx_timer_state_t;

    // The first sample point sits this fraction of a bit period after the start request.
    localparam int unsigned HALF_DIVISOR = 2;

    // Clock cycles from the start request to mid-bit.
    function automatic int unsigned half_period(input int unsigned clks_per_bit);
        return clks_per_bit / HALF_DIVISOR;
    endfunction

endpackage

// File: rtl/sync_rollover_counter.sv
// Up-counter with synchronous clear and a programmable rollover value.
// When enabled at rollover_val it wraps to zero instead of incrementing.
// rollover_flag reports that count_out currently equals rollover_val, so the
// parent can either use it as a wrap indication (while enabled) or as a
// "terminal value reached" status.
module sync_rollover_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             count_enable,
    input  logic [WIDTH-1:0] rollover_val,
    output logic [WIDTH-1:0] count_out,
    output logic             rollover_flag
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             at_rollover;

    assign at_rollover   = (count_q == rollover_val);
    assign rollover_flag = at_rollover;
    assign count_out     = count_q;

    // Next count: clear wins over enable; wrap at the rollover value.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            if (at_rollover) begin
                count_d = '0;
            end else begin
                count_d = count_q + WIDTH'(1'b1);
            end
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rx_bit_timer.sv
// Receive bit-timing controller. After a start request it waits half a bit to
// reach mid-bit, then issues one sample strobe per bit period until a full
// frame has been sampled, and pulses frame_done together with the last strobe.
// One rollover counter measures the bit period, a second counts strobes.
module rx_bit_timer
    import rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT   = 8,
    parameter int unsigned BITS_PER_FRAME = 8,
    parameter int unsigned CNT_BITS       = 4,
    parameter int unsigned IDX_BITS       = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    output logic                busy,
    output logic                sample_strobe,
    output logic [IDX_BITS-1:0] bit_count,
    output logic                frame_done
);

    localparam int unsigned HALF_CLKS = half_period(CLKS_PER_BIT);

    // Last period-counter value in the half-bit and full-bit phases.
    localparam logic [CNT_BITS-1:0] HALF_LAST = CNT_BITS'(HALF_CLKS - 1);
    localparam logic [CNT_BITS-1:0] BIT_LAST  = CNT_BITS'(CLKS_PER_BIT - 1);

    // Strobe count of a complete frame, and the count just before the final strobe.
    localparam logic [IDX_BITS-1:0] FRAME_LEN  = IDX_BITS'(BITS_PER_FRAME);
    localparam logic [IDX_BITS-1:0] FRAME_LAST = IDX_BITS'(BITS_PER_FRAME - 1);

    rx_timer_state_t state_q, state_d;

    logic busy_q, busy_d;
    logic strobe_q, strobe_d;
    logic done_q, done_d;

    // Period counter interface.
    logic                per_clear;
    logic                per_enable;
    logic [CNT_BITS-1:0] per_count;
    logic                per_wrap;

    // Bit counter interface.
    logic                bit_clear;
    logic                bit_enable;
    logic [IDX_BITS-1:0] bit_count_int;
    logic                bit_full;

    // Derived sequencing events.
    logic counting;
    logic half_exit;
    logic run_wrap;
    logic strobe_event;
    logic last_bit;

    // The period counter runs only while timing a bit; it is held at zero in
    // IDLE and DONE, and on abort.
    assign counting  = (state_q == HALF) || (state_q == RUN);
    assign half_exit = (state_q == HALF) && (per_count == HALF_LAST);
    assign run_wrap  = (state_q == RUN) && per_wrap;

    // A strobe is due at mid-bit on leaving HALF and at every full-period wrap.
    assign strobe_event = !abort && (half_exit || run_wrap);

    // The strobe being issued now is the Nth one of the frame.
    assign last_bit = (bit_count_int == FRAME_LAST);

    // Leaving HALF restarts the period count from zero for the first full bit;
    // in RUN the counter wraps on its own at BIT_LAST.
    assign per_clear  = (state_q == IDLE) || (state_q == DONE) || abort || half_exit;
    assign per_enable = counting;

    // bit_count survives through DONE and is cleared on the way back to IDLE.
    // The full guard keeps it from ever stepping past the frame length.
    assign bit_clear  = (state_q == IDLE) || (state_q == DONE) || abort;
    assign bit_enable = strobe_event && !bit_full;

    sync_rollover_counter #(
        .WIDTH (CNT_BITS)
    ) u_period_counter (
        .clk           (clk),
        .rst           (rst),
        .clear         (per_clear),
        .count_enable  (per_enable),
        .rollover_val  (BIT_LAST),
        .count_out     (per_count),
        .rollover_flag (per_wrap)
    );

    sync_rollover_counter #(
        .WIDTH (IDX_BITS)
    ) u_bit_counter (
        .clk           (clk),
        .rst           (rst),
        .clear         (bit_clear),
        .count_enable  (bit_enable),
        .rollover_val  (FRAME_LEN),
        .count_out     (bit_count_int),
        .rollover_flag (bit_full)
    );

    // Next-state and registered-output decode; abort outranks sequencing.
    always_comb begin
        state_d  = state_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = HALF;
                end
            end
            HALF, RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (strobe_event) begin
                    strobe_d = 1'b1;
                    if (last_bit) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            DONE: begin
                // Single completion cycle; start is not looked at here.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
        end
    end

    assign busy          = busy_q;
    assign sample_strobe = strobe_q;
    assign frame_done    = done_q;
    assign bit_count     = bit_count_int;

endmodule
